// File: rtl/risc_core_mc_if.sv
// Host program-load port for risc_core_mc.
// The host side (master) drives memory writes. The core side (slave) receives them.
interface risc_core_mc_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;

    modport master (output prog_we, prog_addr, prog_data);
    modport slave  (input  prog_we, prog_addr, prog_data);
endinterface

// File: rtl/risc_core_mc.sv
// risc_core_mc: multicycle 4-register RISC core with a unified word memory.
// The FSM steps FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB) once per divider tick.
// Run modes: free-run, or single-step on rising edges of step_i.
// A store to LED_ADDR is mirrored to led_o.
// Optional macro RISC_SW_MMIO_EN: a LOAD from SW_ADDR returns sw_i instead of memory.
module risc_core_mc #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                TICK_DIV = 21,
    parameter logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(8'hF5),
    parameter logic [ADDR_W-1:0] SW_ADDR  = ADDR_W'(8'hF4)
) (
    input  logic              CLK_12MHz,
    input  logic              RST,
    input  logic              run_i,
    input  logic              step_i,
    risc_core_mc_if.slave     prog,
    input  logic [DATA_W-1:0] sw_i,
    output logic [DATA_W-1:0] led_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              halted_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        K_ADD, K_SUB, K_LOAD, K_STORE, K_JLEZ, K_JALR, K_ILL, K_HALT, K_LUI, K_LLI
    } kind_t;

    state_t            state_q, state_d;
    kind_t             kind;
    logic              tick;
    logic              go;
    logic              step_q;
    logic              step_pend_q;
    logic              step_rise;
    logic              fetch_fire;

    logic [ADDR_W-1:0] pc_q;
    logic [7:0]        ir_q;
    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] opd_q;      // r[rd]
    logic [DATA_W-1:0] ops_q;      // r[rs]
    logic [DATA_W-1:0] opt_q;      // r[rt]
    logic [DATA_W-1:0] res_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] led_q;
    logic              err_q;

    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] imm_res;
    logic [DATA_W-1:0] load_data;
    logic              jlez_take;
    logic              core_we;
    logic              store_drop;

    logic [1:0]        rd, rs, rt;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    assign rd = ir_q[3:2];
    assign rs = ir_q[1:0];
    assign rt = ir_q[5:4];

    // ------------------------------------------------------------------
    // Tick generation: the FSM only moves when the divider wraps.
    // ------------------------------------------------------------------
    generate
        if (TICK_DIV == 0) begin : g_no_div
            assign tick = 1'b1;
        end else begin : g_div
            logic [TICK_DIV-1:0] div_q;

            // Free-running divider; the all-ones count is the cycle before the wrap.
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            always_ff @(posedge CLK_12MHz or posedge RST) begin
                if (RST) div_q <= '0;
                else     div_q <= div_q + TICK_DIV'(1);
            end

            assign tick = &div_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Single-step control.
    // A rising edge seen while waiting in FETCH is held until the next tick.
    // Edges seen in any other state are dropped, so they are never queued.
    // ------------------------------------------------------------------
    assign step_rise  = step_i & ~step_q;
    assign go         = run_i | step_pend_q | step_rise;
    assign fetch_fire = (state_q == S_FETCH) && tick && go;

    // Step edge detector and pending-request flag.
    always_ff @(posedge CLK_12MHz or posedge RST) begin
        if (RST) begin
            step_q      <= 1'b0;
            step_pend_q <= 1'b0;
        end else begin
            step_q <= step_i;
            if (fetch_fire)
                step_pend_q <= 1'b0;
            else if (step_rise && state_q == S_FETCH)
                step_pend_q <= 1'b1;
        end
    end

    // Instruction class decode from the latched instruction register.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        kind = K_ADD;
        if (ir_q[7:6] == 2'b10)
            kind = K_LUI;
        else if (ir_q[7:6] == 2'b11)
            kind = K_LLI;
        else begin
            unique case (ir_q[6:4])
                3'd0:    kind = K_ADD;
                3'd1:    kind = K_SUB;
                3'd2:    kind = K_LOAD;
                3'd3:    kind = K_STORE;
                3'd4:    kind = K_JLEZ;
                3'd5:    kind = K_JALR;
                3'd6:    kind = K_ILL;
                default: kind = K_HALT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge CLK_12MHz or posedge RST) begin
        if (RST) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state logic; the state only changes on a tick.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                S_FETCH:   if (go) state_d = S_DECODE;
                S_DECODE:  state_d = S_EXECUTE;
                S_EXECUTE: begin
                    unique case (kind)
                        K_ADD, K_SUB:    state_d = S_WB;
                        K_LOAD, K_STORE: state_d = S_MEM;
                        K_HALT, K_ILL:   state_d = S_HALT;
                        default:         state_d = S_FETCH;
                    endcase
                end
                S_MEM:     state_d = (kind == K_LOAD) ? S_WB : S_FETCH;
                S_WB:      state_d = S_FETCH;
                S_HALT:    state_d = S_HALT;
                default:   state_d = S_FETCH;
            endcase
        end
    end

    // Execute-stage arithmetic, immediate merge and branch condition.
    // LUI fills bits [7:4] from imm and copies imm[3] into any bits above 7.
    always_comb begin
        alu_res   = (kind == K_SUB) ? (opd_q - ops_q) : (opd_q + ops_q);
        jlez_take = ops_q[DATA_W-1] | (ops_q == '0);
        imm_res   = opt_q;
        if (kind == K_LUI) begin
            for (int i = 4; i < 8; i++)
                imm_res[i] = ir_q[i-4];
            for (int i = 8; i < DATA_W; i++)
                imm_res[i] = ir_q[3];
        end else begin
            imm_res[3:0] = ir_q[3:0];
        end
    end

    // ------------------------------------------------------------------
    // Load data source
    // ------------------------------------------------------------------
`ifdef RISC_SW_MMIO_EN
    // The switch port replaces the memory word at SW_ADDR.
    always_comb begin
        load_data = mem_q[addr_q];
        if (addr_q == SW_ADDR)
            load_data = sw_i;
    end
`else
    logic unused_sw;
    assign unused_sw = ^{sw_i, SW_ADDR};
    assign load_data = mem_q[addr_q];
`endif

    // ------------------------------------------------------------------
    // Memory
    // A host write to the same address wins over a core store in the same cycle.
    // The store is then dropped entirely.
    // ------------------------------------------------------------------
    assign core_we    = tick && (state_q == S_MEM) && (kind == K_STORE) && !RST;
    assign store_drop = prog.prog_we && (prog.prog_addr == addr_q);

    // Memory write ports: core store, then host load port.
    // NOTE: the memory array is deliberately not reset, so it maps onto plain RAM.
    always_ff @(posedge CLK_12MHz) begin
        if (core_we && !store_drop)
            mem_q[addr_q] <= opd_q;
        if (prog.prog_we)
            mem_q[prog.prog_addr] <= prog.prog_data;
    end

    // ------------------------------------------------------------------
    // Datapath registers. Each state's work is committed on its tick.
    // ------------------------------------------------------------------

    // PC, IR, operand latches, register file, LED register and error flag.
    always_ff @(posedge CLK_12MHz or posedge RST) begin
        if (RST) begin
            pc_q   <= '0;
            ir_q   <= '0;
            opd_q  <= '0;
            ops_q  <= '0;
            opt_q  <= '0;
            res_q  <= '0;
            addr_q <= '0;
            led_q  <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < 4; i++)
                regs_q[i] <= '0;
        end else if (tick) begin
            unique case (state_q)
                S_FETCH: begin
                    if (go) begin
                        ir_q <= mem_q[pc_q][7:0];
                        pc_q <= pc_q + ADDR_W'(1);
                    end
                end
                S_DECODE: begin
                    opd_q <= regs_q[rd];
                    ops_q <= regs_q[rs];
                    opt_q <= regs_q[rt];
                end
                S_EXECUTE: begin
                    unique case (kind)
                        K_ADD, K_SUB:    res_q  <= alu_res;
                        K_LOAD, K_STORE: addr_q <= ADDR_W'(ops_q);
                        K_JLEZ:          if (jlez_take) pc_q <= ADDR_W'(opd_q);
                        K_JALR: begin
                            // opd_q was latched before the link write, so rs==rd
                            // still jumps to the old value.
                            regs_q[rs] <= DATA_W'(pc_q);
                            pc_q       <= ADDR_W'(opd_q);
                        end
                        K_LUI, K_LLI:    regs_q[rt] <= imm_res;
                        K_ILL:           err_q <= 1'b1;
                        default:         ;
                    endcase
                end
                S_MEM: begin
                    if (kind == K_LOAD)
                        res_q <= load_data;
                    else if (addr_q == LED_ADDR && !store_drop)
                        led_q <= opd_q;
                end
                S_WB:    regs_q[rd] <= res_q;
                default: ;
            endcase
        end
    end

    assign led_o    = led_q;
    assign pc_o     = pc_q;
    assign halted_o = (state_q == S_HALT);
    assign err_o    = err_q;

endmodule

// File: tb/tb_risc_core_mc.sv
// Directed testbench for risc_core_mc.
// u_dut0: 8-bit core with TICK_DIV=0, so the FSM ticks every clock.
// u_dut1: 16-bit core with TICK_DIV=2, so the FSM ticks every 4th clock.
module tb_risc_core_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, run0, step0;
    logic [7:0]  sw0, led0, pc0;
    logic        halted0, err0;

    logic        rst1;
    logic [15:0] sw1, led1;
    logic [7:0]  pc1;
    logic        halted1, err1;

    int errors = 0;
    int checks = 0;

    risc_core_mc_if #(.DATA_W(8),  .ADDR_W(8)) if0 ();
    risc_core_mc_if #(.DATA_W(16), .ADDR_W(8)) if1 ();

    risc_core_mc #(.DATA_W(8), .ADDR_W(8), .TICK_DIV(0)) u_dut0 (
        .CLK_12MHz(clk), .RST(rst0), .run_i(run0), .step_i(step0), .prog(if0),
        .sw_i(sw0), .led_o(led0), .pc_o(pc0), .halted_o(halted0), .err_o(err0)
    );

    risc_core_mc #(.DATA_W(16), .ADDR_W(8), .TICK_DIV(2)) u_dut1 (
        .CLK_12MHz(clk), .RST(rst1), .run_i(1'b1), .step_i(1'b0), .prog(if1),
        .sw_i(sw1), .led_o(led1), .pc_o(pc1), .halted_o(halted1), .err_o(err1)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Write n bytes, packed MSB-first in p, starting at base.
    task automatic load(input bit which, input logic [7:0] base, input int n, input logic [63:0] p);
        for (int i = 0; i < n; i++) begin
            if (which == 1'b0) begin
                if0.prog_we   = 1'b1;
                if0.prog_addr = base + 8'(i);
                if0.prog_data = p[8*(n-1-i) +: 8];
            end else begin
                if1.prog_we   = 1'b1;
                if1.prog_addr = base + 8'(i);
                if1.prog_data = {8'h00, p[8*(n-1-i) +: 8]};
            end
            cyc(1);
        end
        if0.prog_we = 1'b0;
        if1.prog_we = 1'b0;
    endtask

    task automatic test_reset();
        rst0 = 1'b1;
        cyc(2);
        checks++; if (pc0 !== 8'h00)   begin errors++; $display("FAIL reset_pc: got %0h want 0", pc0); end
        checks++; if (led0 !== 8'h00)  begin errors++; $display("FAIL reset_led: got %0h want 0", led0); end
        checks++; if (halted0 !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b want 0", halted0); end
        checks++; if (err0 !== 1'b0)   begin errors++; $display("FAIL reset_err: got %0b want 0", err0); end
    endtask

    // LLI A,3; LLI B,4; ADD A,B; LUI C,F; LLI C,5; STORE A->[C]; HALT. Total 23 ticks.
    task automatic test_program();
        rst0 = 1'b1;
        cyc(1);
        load(0, 8'h00, 7, 64'hC3D401AFE53270);
        rst0 = 1'b0;
        cyc(22);
        checks++; if (halted0 !== 1'b0) begin errors++; $display("FAIL prog_halt_early: got %0b want 0", halted0); end
        cyc(1);
        checks++; if (halted0 !== 1'b1) begin errors++; $display("FAIL prog_halted: got %0b want 1", halted0); end
        checks++; if (led0 !== 8'h07)   begin errors++; $display("FAIL prog_led: got %0h want 07", led0); end
        checks++; if (pc0 !== 8'h07)    begin errors++; $display("FAIL prog_pc: got %0h want 07", pc0); end
        checks++; if (err0 !== 1'b0)    begin errors++; $display("FAIL prog_err: got %0b want 0", err0); end
    endtask

    // LLI B,1; SUB A,B (0-1); LUI C,F; LLI C,5; STORE A->[C]; HALT. Total 20 ticks.
    task automatic test_sub_wrap();
        rst0 = 1'b1;
        cyc(1);
        load(0, 8'h00, 6, 64'hD111AFE53270);
        rst0 = 1'b0;
        cyc(24);
        checks++; if (led0 !== 8'hFF)   begin errors++; $display("FAIL sub_wrap8_led: got %0h want ff", led0); end
        checks++; if (halted0 !== 1'b1) begin errors++; $display("FAIL sub_wrap8_halted: got %0b want 1", halted0); end
    endtask

    // The same SUB program on the 16-bit, divided-clock core.
    // The n-th tick falls on clock 4n, so HALT is reached on clock 80.
    task automatic test_div16();
        rst1 = 1'b1;
        cyc(1);
        load(1, 8'h00, 6, 64'hD111AFE53270);
        rst1 = 1'b0;
        cyc(79);
        checks++; if (halted1 !== 1'b0)  begin errors++; $display("FAIL div16_halt_early: got %0b want 0", halted1); end
        cyc(1);
        checks++; if (halted1 !== 1'b1)  begin errors++; $display("FAIL div16_halted: got %0b want 1", halted1); end
        checks++; if (led1 !== 16'hFFFF) begin errors++; $display("FAIL div16_sub_wrap_led: got %0h want ffff", led1); end
        checks++; if (pc1 !== 8'h06)     begin errors++; $display("FAIL div16_pc: got %0h want 06", pc1); end
        checks++; if (err1 !== 1'b0)     begin errors++; $display("FAIL div16_err: got %0b want 0", err1); end
    endtask

    // A=FF, B=20, then one JLEZ, then HALT at 4. A HALT also sits at 0x20.
    // Final pc is 5 if the branch falls through, 0x21 if it jumps.
    task automatic run_jlez(input logic [7:0] jop, input logic [7:0] want_pc, input string name);
        rst0 = 1'b1;
        cyc(1);
        load(0, 8'h20, 1, 64'h70);
        load(0, 8'h00, 5, {24'h0, 8'h8F, 8'hCF, 8'h92, jop, 8'h70});
        rst0 = 1'b0;
        cyc(18);
        checks++; if (halted0 !== 1'b1) begin errors++; $display("FAIL %s_halted: got %0b want 1", name, halted0); end
        checks++; if (pc0 !== want_pc)  begin errors++; $display("FAIL %s_pc: got %0h want %0h", name, pc0, want_pc); end
    endtask

    task automatic test_jlez();
        run_jlez(8'h41, 8'h05, "jlez_positive");
        run_jlez(8'h44, 8'h21, "jlez_negative");
        run_jlez(8'h46, 8'h21, "jlez_zero");
    endtask

    // LUI A,1 (A=0x10); JALR rd=A rs=A. The link value 2 overwrites A.
    // The jump still goes to the old value 0x10, where A is stored to the LEDs.
    task automatic test_jalr();
        rst0 = 1'b1;
        cyc(1);
        load(0, 8'h00, 2, 64'h8150);
        load(0, 8'h10, 4, 64'hBFF53370);
        rst0 = 1'b0;
        cyc(25);
        checks++; if (led0 !== 8'h02)   begin errors++; $display("FAIL jalr_link: got %0h want 02", led0); end
        checks++; if (pc0 !== 8'h14)    begin errors++; $display("FAIL jalr_pc: got %0h want 14", pc0); end
        checks++; if (halted0 !== 1'b1) begin errors++; $display("FAIL jalr_halted: got %0b want 1", halted0); end
    endtask

    // C=F4; LOAD A<-[C]; D=F5; STORE A->[D]; HALT. mem[F4]=33 and sw_i=5A.
    task automatic test_load_sw();
        logic [7:0] want;
`ifdef RISC_SW_MMIO_EN
        want = 8'h5A;
`else
        want = 8'h33;
`endif
        rst0 = 1'b1;
        cyc(1);
        load(0, 8'hF4, 1, 64'h33);
        load(0, 8'h00, 7, 64'hAFE422BFF53370);
        rst0 = 1'b0;
        cyc(28);
        checks++; if (led0 !== want)    begin errors++; $display("FAIL load_sw_addr: got %0h want %0h", led0, want); end
        checks++; if (halted0 !== 1'b1) begin errors++; $display("FAIL load_halted: got %0b want 1", halted0); end
    endtask

    // Read mem[F5] back through a LOAD, then STORE it to the LEDs.
    task automatic readback_f5(input logic [7:0] want, input string name);
        rst0 = 1'b1;
        cyc(1);
        load(0, 8'h00, 5, 64'hBFF5233370);
        rst0 = 1'b0;
        cyc(22);
        checks++; if (led0 !== want) begin errors++; $display("FAIL %s: got %0h want %0h", name, led0, want); end
    endtask

    // D=F5; A=7; STORE A->[D]. Reset is asserted while that STORE sits in MEM (after tick 12).
    task automatic test_reset_midop();
        rst0 = 1'b1;
        cyc(1);
        load(0, 8'hF5, 1, 64'h11);
        load(0, 8'h00, 5, 64'hBFF5C73370);
        rst0 = 1'b0;
        cyc(12);
        rst0 = 1'b1;
        cyc(1);
        checks++; if (led0 !== 8'h00) begin errors++; $display("FAIL midop_led: got %0h want 0", led0); end
        checks++; if (pc0 !== 8'h00)  begin errors++; $display("FAIL midop_pc: got %0h want 0", pc0); end
        readback_f5(8'h11, "midop_mem_unchanged");
    endtask

    // A host write to F5 lands on the same clock as the core STORE to F5.
    task automatic test_prog_priority();
        rst0 = 1'b1;
        cyc(1);
        load(0, 8'h00, 5, 64'hBFF5C73370);
        rst0 = 1'b0;
        cyc(12);
        if0.prog_we   = 1'b1;
        if0.prog_addr = 8'hF5;
        if0.prog_data = 8'h99;
        cyc(1);
        if0.prog_we   = 1'b0;
        cyc(5);
        checks++; if (halted0 !== 1'b1) begin errors++; $display("FAIL prio_halted: got %0b want 1", halted0); end
        checks++; if (led0 !== 8'h00)   begin errors++; $display("FAIL prio_led_untouched: got %0h want 0", led0); end
        readback_f5(8'h99, "prio_host_wins");
    endtask

    task automatic pulse_step();
        step0 = 1'b1;
        cyc(1);
        step0 = 1'b0;
    endtask

    task automatic test_step();
        run0 = 1'b0;
        rst0 = 1'b1;
        cyc(1);
        load(0, 8'h00, 5, 64'h0101010101);
        rst0 = 1'b0;
        cyc(10);
        checks++; if (pc0 !== 8'h00) begin errors++; $display("FAIL step_hold: got %0h want 0", pc0); end
        for (int i = 0; i < 3; i++) begin
            pulse_step();
            cyc(9);
        end
        checks++; if (pc0 !== 8'h03) begin errors++; $display("FAIL step_three: got %0h want 3", pc0); end
        pulse_step();
        checks++; if (pc0 !== 8'h04) begin errors++; $display("FAIL step_fourth: got %0h want 4", pc0); end
        cyc(1);
        pulse_step();
        cyc(20);
        checks++; if (pc0 !== 8'h04) begin errors++; $display("FAIL step_mid_ignored: got %0h want 4", pc0); end
        run0 = 1'b1;
    endtask

    task automatic test_illegal();
        rst0 = 1'b1;
        cyc(1);
        load(0, 8'h00, 1, 64'h60);
        rst0 = 1'b0;
        cyc(2);
        checks++; if (halted0 !== 1'b0) begin errors++; $display("FAIL ill_halt_early: got %0b want 0", halted0); end
        cyc(1);
        checks++; if (halted0 !== 1'b1) begin errors++; $display("FAIL ill_halted: got %0b want 1", halted0); end
        checks++; if (err0 !== 1'b1)    begin errors++; $display("FAIL ill_err: got %0b want 1", err0); end
        checks++; if (pc0 !== 8'h01)    begin errors++; $display("FAIL ill_pc: got %0h want 1", pc0); end
        cyc(5);
        checks++; if (pc0 !== 8'h01)    begin errors++; $display("FAIL ill_pc_frozen: got %0h want 1", pc0); end
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        run0 = 1'b1;
        step0 = 1'b0;
        sw0 = 8'h5A;
        sw1 = 16'h005A;
        if0.prog_we = 1'b0;
        if0.prog_addr = '0;
        if0.prog_data = '0;
        if1.prog_we = 1'b0;
        if1.prog_addr = '0;
        if1.prog_data = '0;
        #2;

        test_reset();
        test_program();
        test_sub_wrap();
        test_div16();
        test_jlez();
        test_jalr();
        test_load_sw();
        test_reset_midop();
        test_prog_priority();
        test_step();
        test_illegal();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
